// File: rtl/eth_mac_pkg.sv
// rtl/eth_mac_pkg.sv - shared types, framing constants and byte-wise CRC-32 step for the MAC transmitter
package eth_mac_pkg;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int unsigned MIN_DATA_LEN  = 60;
  localparam int unsigned PREAMBLE_LEN  = 7;

  // Reflected CRC: bits leave LSB first, so the polynomial is applied bit-reversed.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] poly_r;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) poly_r[i] = CRC_POLY[31-i];
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_mac_tx_if.sv
// rtl/eth_mac_tx_if.sv - AXI-Stream user frame interface into the MAC transmitter
interface eth_mac_tx_if;
  logic [7:0] tx_axis_mac_tdata;
  logic       tx_axis_mac_tvalid;
  logic       tx_axis_mac_tlast;
  logic       tx_axis_mac_tready;

  modport master (output tx_axis_mac_tdata, output tx_axis_mac_tvalid,
                  output tx_axis_mac_tlast, input tx_axis_mac_tready);
  modport slave  (input tx_axis_mac_tdata, input tx_axis_mac_tvalid,
                  input tx_axis_mac_tlast, output tx_axis_mac_tready);
endinterface

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - running CRC-32 register, one byte per enabled cycle
module eth_crc32
  import eth_mac_pkg::*;
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = CRC_INIT;
    else if (en_i) crc_d = crc32_byte(crc_q, data_i);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) crc_q <= CRC_INIT;
    else           crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/eth_mac_tx.sv
// rtl/eth_mac_tx.sv - Ethernet MAC transmit framer: preamble/SFD, data, optional pad, FCS, IFG
// Short-frame padding is built only when TX_PAD_EN is defined.
module eth_mac_tx
  import eth_mac_pkg::*;
#(
  parameter int unsigned C_IFG = 96
) (
  input  logic         tx_mac_aclk,
  input  logic         tx_mac_resetn,
  input  logic         tx_byte_en,
  eth_mac_tx_if.slave  s_axis,
  output logic [7:0]   gmii_txd,
  output logic         gmii_tx_en,
  output logic         gmii_tx_er
);
  localparam int unsigned IFG_SLOTS = C_IFG / 8;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  dcnt_q, dcnt_d, dcnt_inc;
  logic        drop_q, drop_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, er_q, er_d;
  logic [31:0] crc, fcs_shift;
  logic        hs, pad_slot;

  assign hs        = tx_byte_en && (state_q == DATA) && s_axis.tx_axis_mac_tvalid;
  assign dcnt_inc  = (dcnt_q == 6'(MIN_DATA_LEN)) ? dcnt_q : dcnt_q + 6'd1;
  assign fcs_shift = ~crc >> {cnt_q[1:0], 3'b000};
`ifdef TX_PAD_EN
  assign pad_slot  = tx_byte_en && (state_q == PAD);
`else
  assign pad_slot  = 1'b0;
`endif

  // After an underrun the rest of the user frame is drained while the gap runs.
  assign s_axis.tx_axis_mac_tready = tx_byte_en && ((state_q == DATA) || (state_q == IFG && drop_q));

  eth_crc32 u_crc (
    .clk_i    (tx_mac_aclk),
    .resetn_i (tx_mac_resetn),
    .init_i   (tx_byte_en && state_q == PREAMBLE),
    .en_i     (hs || pad_slot),
    .data_i   (pad_slot ? 8'h00 : s_axis.tx_axis_mac_tdata),
    .crc_o    (crc)
  );

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      drop_q  <= 1'b0;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      drop_q  <= drop_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    drop_d  = drop_q;
    if (tx_byte_en) begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          dcnt_d = '0;
          if (s_axis.tx_axis_mac_tvalid) state_d = PREAMBLE;
        end
        PREAMBLE: begin
          if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
            cnt_d   = '0;
            state_d = SFD;
          end else cnt_d = cnt_q + 16'd1;
        end
        SFD: state_d = DATA;
        DATA: begin
          cnt_d = '0;
          if (!s_axis.tx_axis_mac_tvalid) begin
            drop_d  = 1'b1;
            state_d = IFG;
          end else begin
            dcnt_d = dcnt_inc;
            if (s_axis.tx_axis_mac_tlast) begin
`ifdef TX_PAD_EN
              state_d = (dcnt_inc < 6'(MIN_DATA_LEN)) ? PAD : FCS;
`else
              state_d = FCS;
`endif
            end
          end
        end
`ifdef TX_PAD_EN
        PAD: begin
          dcnt_d = dcnt_inc;
          if (dcnt_inc == 6'(MIN_DATA_LEN)) state_d = FCS;
        end
`endif
        FCS: begin
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = '0;
            state_d = IFG;
          end else cnt_d = cnt_q + 16'd1;
        end
        IFG: begin
          if (drop_q && s_axis.tx_axis_mac_tvalid && s_axis.tx_axis_mac_tlast) drop_d = 1'b0;
          if (cnt_q >= 16'(IFG_SLOTS - 1)) begin
            if (!drop_q) state_d = IDLE;
          end else cnt_d = cnt_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    txd_d = txd_q;
    en_d  = en_q;
    er_d  = er_q;
    if (tx_byte_en) begin
      txd_d = 8'h00;
      en_d  = 1'b0;
      er_d  = 1'b0;
      case (state_q)
        PREAMBLE: begin txd_d = PREAMBLE_BYTE; en_d = 1'b1; end
        SFD:      begin txd_d = SFD_BYTE;      en_d = 1'b1; end
        DATA: begin
          en_d = 1'b1;
          if (s_axis.tx_axis_mac_tvalid) txd_d = s_axis.tx_axis_mac_tdata;
          else                           er_d  = 1'b1;
        end
`ifdef TX_PAD_EN
        PAD:      en_d = 1'b1;
`endif
        FCS:      begin txd_d = fcs_shift[7:0]; en_d = 1'b1; end
        default: ;
      endcase
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
endmodule

// File: tb/tb_eth_mac_tx.sv
// tb/tb_eth_mac_tx.sv - directed self-checking bench for eth_mac_tx
module tb_eth_mac_tx;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       byte_en = 1'b1;
  logic [7:0] txd;
  logic       txen, txer;
  int         checks = 0;
  int         errors = 0;

  eth_mac_tx_if axis ();

  eth_mac_tx #(.C_IFG(96)) dut (
    .tx_mac_aclk   (clk),
    .tx_mac_resetn (rstn),
    .tx_byte_en    (byte_en),
    .s_axis        (axis),
    .gmii_txd      (txd),
    .gmii_tx_en    (txen),
    .gmii_tx_er    (txer)
  );

  always #4 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic en; logic er;} slot_t;
  slot_t mon_q[$];
  slot_t last_s;
  int    en_cnt = 0;
  int    hold_err = 0;
  bit    hold_chk = 0;
  bit    slow = 0;
  int    rd = 0;

  initial begin
    int c = 0;
    forever begin
      @(posedge clk); #1;
      c++;
      byte_en = slow ? (c % 10 == 0) : 1'b1;
    end
  end

  initial begin
    logic be;
    forever begin
      @(posedge clk);
      be = byte_en;
      #1;
      if (be) begin
        last_s = '{txd, txen, txer};
        mon_q.push_back(last_s);
        if (txen) en_cnt++;
      end else if (hold_chk && (slot_t'({txd, txen, txer}) !== last_s)) hold_err++;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [31:0] r;
    logic        fb;
    foreach (b[i])
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ b[i][j];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  function automatic void add_hdr(ref logic [7:0] q[$]);
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
  endfunction

  task automatic send(input logic [7:0] b[$], input int drop_at, output int stalls);
    int idx = 0;
    int budget = 0;
    bit dropped = 0, started = 0, done = 0, hs;
    stalls = 0;
    while (!done && budget < 40000) begin
      axis.tx_axis_mac_tvalid = !(idx == drop_at && !dropped);
      axis.tx_axis_mac_tdata  = b[idx];
      axis.tx_axis_mac_tlast  = (idx == b.size() - 1);
      @(negedge clk);
      budget++;
      hs = byte_en && axis.tx_axis_mac_tready;
      if (started && byte_en && !axis.tx_axis_mac_tready) stalls++;
      if (hs) begin
        started = 1;
        if (!axis.tx_axis_mac_tvalid) dropped = 1;
        else begin
          if (axis.tx_axis_mac_tlast) done = 1;
          idx++;
        end
      end
      @(posedge clk); #1;
    end
    axis.tx_axis_mac_tvalid = 1'b0;
    axis.tx_axis_mac_tlast  = 1'b0;
    if (!done) chk(32'd0, 32'd1, "send_timeout");
  endtask

  // Locates the next frame from rd, compares it and the 12 idle gap slots after it.
  task automatic check_frame(input logic [7:0] exp[$], input string tag, output int lead);
    int p = rd;
    int bad = 0, gap_bad = 0;
    while (p < mon_q.size() && !mon_q[p].en) p++;
    lead = p - rd;
    foreach (exp[i])
      if (p + i >= mon_q.size() || mon_q[p+i] !== slot_t'({exp[i], 1'b1, 1'b0})) bad++;
    chk(bad, 0, {tag, "_bytes"});
    for (int i = 0; i < 12; i++)
      if (p + exp.size() + i >= mon_q.size() ||
          mon_q[p+exp.size()+i] !== slot_t'({8'h00, 1'b0, 1'b0})) gap_bad++;
    chk(gap_bad, 0, {tag, "_ifg"});
    rd = p + exp.size() + 12;
  endtask

  task automatic fresh();
    @(posedge clk); #2;
    mon_q.delete();
    rd = 0;
  endtask

  initial begin
    logic [7:0] d9[$], e9[$], dl[$], el[$], ds[$], es[$], du[$], dd[$];
    logic [31:0] f;
    int lead, stalls, p, bad, ers;

    axis.tx_axis_mac_tvalid = 1'b0;
    axis.tx_axis_mac_tlast  = 1'b0;
    axis.tx_axis_mac_tdata  = 8'h00;
    for (int i = 0; i < 9; i++) d9.push_back(8'h31 + 8'(i));
    add_hdr(e9);
    foreach (d9[i]) e9.push_back(d9[i]);
    e9.push_back(8'h26); e9.push_back(8'h39); e9.push_back(8'hF4); e9.push_back(8'hCB);

    #5;
    chk(txd, 8'h00, "rst_txd");
    chk(txen, 1'b0, "rst_en");
    chk(txer, 1'b0, "rst_er");
    chk(axis.tx_axis_mac_tready, 1'b0, "rst_tready");
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(posedge clk);

    // "123456789" then a back-to-back copy
    fresh();
    send(d9, -1, stalls);
    send(d9, -1, stalls);
    repeat (40) @(posedge clk);
    check_frame(e9, "f9", lead);
    chk(lead, 1, "f9_lead");
    check_frame(e9, "b2b", lead);
    chk(lead, 1, "b2b_lead");

    // 1514-byte frame
    for (int i = 0; i < 1514; i++) dl.push_back(8'(i * 7 + 3));
    add_hdr(el);
    foreach (dl[i]) el.push_back(dl[i]);
    f = ref_fcs(dl);
    for (int k = 0; k < 4; k++) el.push_back(8'(f >> (8 * k)));
    fresh();
    send(dl, -1, stalls);
    repeat (40) @(posedge clk);
    chk(stalls, 0, "long_stalls");
    check_frame(el, "long", lead);

    // 14-byte frame, padded to 60 when the pad feature is built
    for (int i = 0; i < 14; i++) ds.push_back(8'hA0 + 8'(i));
    add_hdr(es);
    foreach (ds[i]) es.push_back(ds[i]);
`ifdef TX_PAD_EN
    for (int i = 14; i < 60; i++) ds.push_back(8'h00);
`endif
    for (int i = 14; i < ds.size(); i++) es.push_back(8'h00);
    f = ref_fcs(ds);
    for (int k = 0; k < 4; k++) es.push_back(8'(f >> (8 * k)));
    ds = ds[0:13];
    fresh();
    send(ds, -1, stalls);
    repeat (40) @(posedge clk);
    check_frame(es, "short", lead);

    // Underrun at byte 20 of a 40-byte frame, then a normal frame
    for (int i = 0; i < 40; i++) du.push_back(8'(i + 1));
    fresh();
    send(du, 20, stalls);
    send(d9, -1, stalls);
    repeat (40) @(posedge clk);
    p = 0;
    while (p < mon_q.size() && !mon_q[p].en) p++;
    bad = 0;
    add_hdr(dd);
    for (int i = 0; i < 20; i++) dd.push_back(du[i]);
    foreach (dd[i])
      if (p + i >= mon_q.size() || mon_q[p+i] !== slot_t'({dd[i], 1'b1, 1'b0})) bad++;
    chk(bad, 0, "urun_bytes");
    chk((p + 28 < mon_q.size()) ? {mon_q[p+28].en, mon_q[p+28].er} : 2'b00, 2'b11, "urun_er");
    bad = 0;
    for (int i = 29; i < 41; i++) if (p + i >= mon_q.size() || mon_q[p+i].en) bad++;
    chk(bad, 0, "urun_no_fcs");
    rd = p + 41;
    check_frame(e9, "after_urun", lead);
    ers = 0;
    foreach (mon_q[i]) if (mon_q[i].er) ers++;
    chk(ers, 1, "urun_er_count");

    // 100M pacing: same bytes, each held between strobes
    slow = 1;
    repeat (25) @(posedge clk);
    fresh();
    hold_err = 0;
    hold_chk = 1;
    send(d9, -1, stalls);
    repeat (400) @(posedge clk);
    hold_chk = 0;
    check_frame(e9, "slow", lead);
    chk(hold_err, 0, "slow_hold");
    slow = 0;
    repeat (25) @(posedge clk);

    // Reset while the second FCS byte is on the wire
    fresh();
    en_cnt = 0;
    send(d9, -1, stalls);
    p = 0;
    while (en_cnt < 19 && p < 100) begin @(posedge clk); #2; p++; end
    chk({txd, txen}, {8'h39, 1'b1}, "fcs2_before_rst");
    rstn = 1'b0;
    #1;
    chk({txd, txen, txer, axis.tx_axis_mac_tready}, 11'd0, "rst_mid_fcs");
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(posedge clk);
    fresh();
    send(d9, -1, stalls);
    repeat (40) @(posedge clk);
    check_frame(e9, "post_rst", lead);
    chk(lead, 1, "post_rst_lead");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
